path_mailbox: RTL and testbench
===============================

PATH_MAILBOX -- requirements
Module: path_mailbox

Interface
REQ-001 SHALL have parameter NODE_W, default 5: node-ID width; applies to sp, ep and each path entry.
REQ-002 SHALL have parameter PATH_DEPTH, default 8: maximum number of captured path entries, range 2..32.
REQ-003 SHALL have parameter ARG_BASE, default 32'h0200_0000: word address where sp is written; ep is written at ARG_BASE+4.
REQ-004 SHALL have parameter PATH_BASE, default 32'h0200_0010: address of path slot 0; slot i is at PATH_BASE+4*i.
REQ-005 SHALL have parameter LEN_ADDR, default 32'h0200_000C: CPU writes the path length here to signal completion.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 1_000_000: maximum number of RUN cycles.
REQ-007 clk  in  1  single clock; all state changes on the rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle request to load sp/ep and run the CPU.
REQ-010 sp, ep  in  NODE_W each  start and end nodes, sampled on an accepted start.
REQ-011 ack  in  1  host acknowledge; releases DONE or TIMEOUT.
REQ-012 mem_we, mem_adr, mem_wdata  in  1/32/32  snooped data-memory write port (post-mux).
REQ-013 cpu_reset  out  1  active-high hold for the CPU core.
REQ-014 ext_active, ext_memwrite, ext_dataadr, ext_writedata  out  1/1/32/32  external memory-write port; the top-level mux selects it while ext_active=1.
REQ-015 path_nodes  out  PATH_DEPTH*NODE_W  slot i occupies bits [i*NODE_W +: NODE_W].
REQ-016 path_len  out  $clog2(PATH_DEPTH+1)  captured path length.
REQ-017 done, path_found, timeout, busy  out  1 each  status flags.

Function
REQ-018 FSM states SHALL be: IDLE, LOAD_SP, LOAD_EP, RUN, DONE, TOUT.
REQ-019 IDLE with start=1 SHALL latch sp/ep, clear all slots, path_len and flags, and go to LOAD_SP; start in any other state SHALL be ignored.
REQ-020 LOAD_SP SHALL drive ext_active=1, ext_memwrite=1, ext_dataadr=ARG_BASE and ext_writedata={zero-extended sp} for exactly one cycle, then go to LOAD_EP.
REQ-021 LOAD_EP SHALL do the same with ARG_BASE+4 and ep, then go to RUN.
REQ-022 cpu_reset SHALL be 1 in every state except RUN; the CPU is released on the first RUN cycle, two cycles after the start edge.
REQ-023 In RUN, a write with mem_we=1, mem_adr[1:0]=0 and PATH_BASE<=mem_adr<=PATH_BASE+4*(PATH_DEPTH-1) SHALL store mem_wdata[NODE_W-1:0] into the addressed slot on the same edge; a later write to the same slot SHALL overwrite it.
REQ-024 Writes that are misaligned, out of range, or made outside RUN SHALL be ignored.
REQ-025 In RUN, a write to LEN_ADDR SHALL set path_len to min(mem_wdata, PATH_DEPTH), set done=1 and path_found=(path_len!=0), and go to DONE.
REQ-026 The RUN cycle counter SHALL clear on entry to RUN; when it reaches TIMEOUT_CYC-1 without a LEN_ADDR write, the FSM SHALL go to TOUT with timeout=1 and done=1. A LEN_ADDR write on that same cycle SHALL win.
REQ-027 In DONE or TOUT, ack=1 SHALL return the FSM to IDLE; flags and slots SHALL hold until the next accepted start.
REQ-028 busy SHALL be 1 in LOAD_SP, LOAD_EP and RUN.
REQ-029 ext_memwrite, ext_dataadr and ext_writedata SHALL be 0 whenever ext_active=0.

Reset
REQ-030 reset_n=0 SHALL immediately force: state=IDLE, cpu_reset=1, ext_*=0, all slots=0, path_len=0, done=path_found=timeout=busy=0, counter=0.
REQ-031 A reset asserted mid-LOAD or mid-RUN SHALL abort the run with no partial flags, and the CPU SHALL remain held.

Structure
REQ-032 Package path_mailbox_pkg SHALL hold the state enum, the default address constants and the timeout default.
REQ-033 Slot storage and the address decode SHALL be one sub-module, path_slot_file, parametrised by NODE_W, PATH_DEPTH and PATH_BASE.

Verification
REQ-034 start with sp=3, ep=17 -> writes to ARG_BASE=3 and ARG_BASE+4=17 on cycles 1 and 2; cpu_reset falls at cycle 3.
REQ-035 RUN; slots 0..4 written with 3,7,9,12,17; LEN_ADDR=5 -> path_len=5, path_found=1, done=1, path_nodes low 5 slots match, cpu_reset=1 the next cycle.
REQ-036 LEN_ADDR=0 -> done=1, path_found=0; LEN_ADDR=40 -> path_len=PATH_DEPTH.
REQ-037 Writes to PATH_BASE+2, PATH_BASE+4*PATH_DEPTH, and slot writes while in DONE -> no slot changes.
REQ-038 TIMEOUT_CYC=16 with no LEN_ADDR write -> timeout=1 at RUN cycle 16; ack -> IDLE; a second start during RUN is ignored.
REQ-039 reset_n pulse mid-RUN after 3 slot writes -> all outputs return to reset values asynchronously, and cpu_reset=1.

Source files
------------

// File: rtl/path_mailbox_pkg.sv
// rtl/path_mailbox_pkg.sv - shared state encoding and default address map for the path mailbox
package path_mailbox_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_SP,
        S_LOAD_EP,
        S_RUN,
        S_DONE,
        S_TOUT
    } state_t;

    localparam logic [31:0] DEF_ARG_BASE    = 32'h0200_0000;
    localparam logic [31:0] DEF_PATH_BASE   = 32'h0200_0010;
    localparam logic [31:0] DEF_LEN_ADDR    = 32'h0200_000C;
    localparam int          DEF_TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/path_mailbox_if.sv
// rtl/path_mailbox_if.sv - snooped CPU data-memory writes and the external write port toward the memory mux
interface path_mailbox_if;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        ext_active;
    logic        ext_memwrite;
    logic [31:0] ext_dataadr;
    logic [31:0] ext_writedata;

    modport master (
        input  mem_we, mem_adr, mem_wdata,
        output ext_active, ext_memwrite, ext_dataadr, ext_writedata
    );

    modport slave (
        output mem_we, mem_adr, mem_wdata,
        input  ext_active, ext_memwrite, ext_dataadr, ext_writedata
    );
endinterface

// File: rtl/path_mailbox_slot_file.sv
// rtl/path_mailbox_slot_file.sv - path slot storage with word-exact address decode
module path_slot_file
    import path_mailbox_pkg::*;
#(
    parameter int          NODE_W     = 5,
    parameter int          PATH_DEPTH = 8,
    parameter logic [31:0] PATH_BASE  = DEF_PATH_BASE
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_clear,
    input  logic                         i_we,
    input  logic [31:0]                  i_adr,
    input  logic [NODE_W-1:0]            i_wdata,
    output logic [PATH_DEPTH*NODE_W-1:0] o_nodes
);

    logic [PATH_DEPTH-1:0][NODE_W-1:0] r_slots;

    // A full-width compare per slot rejects misaligned and out-of-range addresses in one step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slots <= '0;
        end else if (i_clear) begin
            r_slots <= '0;
        end else if (i_we) begin
            for (int i = 0; i < PATH_DEPTH; i++) begin
                if (i_adr == PATH_BASE + 32'(4 * i)) begin
                    r_slots[i] <= i_wdata;
                end
            end
        end
    end

    assign o_nodes = r_slots;

endmodule

// File: rtl/path_mailbox.sv
// rtl/path_mailbox.sv - loads sp/ep into CPU memory, runs the CPU and captures the path it writes back
module path_mailbox
    import path_mailbox_pkg::*;
#(
    parameter int          NODE_W      = 5,
    parameter int          PATH_DEPTH  = 8,
    parameter logic [31:0] ARG_BASE    = DEF_ARG_BASE,
    parameter logic [31:0] PATH_BASE   = DEF_PATH_BASE,
    parameter logic [31:0] LEN_ADDR    = DEF_LEN_ADDR,
    parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [NODE_W-1:0]                sp,
    input  logic [NODE_W-1:0]                ep,
    input  logic                             ack,
    path_mailbox_if.master                   bus,
    output logic                             cpu_reset,
    output logic [PATH_DEPTH*NODE_W-1:0]     path_nodes,
    output logic [$clog2(PATH_DEPTH+1)-1:0]  path_len,
    output logic                             done,
    output logic                             path_found,
    output logic                             timeout,
    output logic                             busy
);

    localparam int LEN_W = $clog2(PATH_DEPTH + 1);

    state_t             r_state, w_next;
    logic [NODE_W-1:0]  r_sp, r_ep;
    logic [31:0]        r_cnt;
    logic               w_start_ok, w_len_hit, w_tout_hit;
    logic [LEN_W-1:0]   w_len_val;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_len_hit  = (r_state == S_RUN) && bus.mem_we && (bus.mem_adr == LEN_ADDR);
    assign w_tout_hit = (r_state == S_RUN) && (r_cnt == 32'(TIMEOUT_CYC - 1));
    assign w_len_val  = (bus.mem_wdata > 32'(PATH_DEPTH)) ? LEN_W'(PATH_DEPTH)
                                                          : bus.mem_wdata[LEN_W-1:0];

    always_comb begin
        w_next            = r_state;
        cpu_reset         = 1'b1;
        busy              = 1'b0;
        bus.ext_active    = 1'b0;
        bus.ext_memwrite  = 1'b0;
        bus.ext_dataadr   = '0;
        bus.ext_writedata = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD_SP;
            end
            S_LOAD_SP: begin
                busy              = 1'b1;
                bus.ext_active    = 1'b1;
                bus.ext_memwrite  = 1'b1;
                bus.ext_dataadr   = ARG_BASE;
                bus.ext_writedata = 32'(r_sp);
                w_next            = S_LOAD_EP;
            end
            S_LOAD_EP: begin
                busy              = 1'b1;
                bus.ext_active    = 1'b1;
                bus.ext_memwrite  = 1'b1;
                bus.ext_dataadr   = ARG_BASE + 32'd4;
                bus.ext_writedata = 32'(r_ep);
                w_next            = S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                cpu_reset = 1'b0;
                // Completion beats the timeout when both land on the same cycle.
                if (w_len_hit)       w_next = S_DONE;
                else if (w_tout_hit) w_next = S_TOUT;
            end
            S_DONE, S_TOUT: begin
                if (ack) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sp       <= '0;
            r_ep       <= '0;
            r_cnt      <= '0;
            path_len   <= '0;
            done       <= 1'b0;
            path_found <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_RUN) ? r_cnt + 32'd1 : 32'd0;
            if (w_start_ok) begin
                r_sp       <= sp;
                r_ep       <= ep;
                path_len   <= '0;
                done       <= 1'b0;
                path_found <= 1'b0;
                timeout    <= 1'b0;
            end else if (w_len_hit) begin
                path_len   <= w_len_val;
                done       <= 1'b1;
                path_found <= (w_len_val != '0);
            end else if (w_tout_hit) begin
                done    <= 1'b1;
                timeout <= 1'b1;
            end
        end
    end

    path_slot_file #(
        .NODE_W     (NODE_W),
        .PATH_DEPTH (PATH_DEPTH),
        .PATH_BASE  (PATH_BASE)
    ) u_slots (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_start_ok),
        .i_we    ((r_state == S_RUN) && bus.mem_we),
        .i_adr   (bus.mem_adr),
        .i_wdata (bus.mem_wdata[NODE_W-1:0]),
        .o_nodes (path_nodes)
    );

endmodule

// File: tb/tb_path_mailbox.sv
// tb/tb_path_mailbox.sv - directed vector bench for path_mailbox
module tb_path_mailbox;

    localparam int          NODE_W = 5;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] AB     = 32'h0200_0000;
    localparam logic [31:0] PB     = 32'h0200_0010;
    localparam logic [31:0] LA     = 32'h0200_000C;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    start = 1'b0;
    logic                    ack = 1'b0;
    logic [NODE_W-1:0]       sp = '0, ep = '0;
    logic                    cpu_reset, done, path_found, timeout, busy;
    logic [DEPTH*NODE_W-1:0] path_nodes;
    logic [3:0]              path_len;

    int n_tests = 0;
    int n_fail  = 0;

    path_mailbox_if bus_if ();

    path_mailbox #(.TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .sp         (sp),
        .ep         (ep),
        .ack        (ack),
        .bus        (bus_if.master),
        .cpu_reset  (cpu_reset),
        .path_nodes (path_nodes),
        .path_len   (path_len),
        .done       (done),
        .path_found (path_found),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [39:0] exp;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        @(negedge clk);
        bus_if.mem_we    = we;
        bus_if.mem_adr   = adr;
        bus_if.mem_wdata = wd;
        @(posedge clk);
        #1;
        bus_if.mem_we = 1'b0;
    endtask

    task automatic go_run(input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] e);
        @(negedge clk);
        start = 1'b1;
        sp = s;
        ep = e;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " cpu_reset"}, 64'(cpu_reset), 64'd1);
        chk({tag, " ext"}, {bus_if.ext_active, bus_if.ext_memwrite, 62'(bus_if.ext_dataadr | bus_if.ext_writedata)}, 64'd0);
        chk({tag, " nodes"}, 64'(path_nodes), 64'd0);
        chk({tag, " flags"}, {56'd0, path_len, done, path_found, timeout, busy}, 64'd0);
    endtask

    initial begin
        bus_if.mem_we    = 1'b0;
        bus_if.mem_adr   = '0;
        bus_if.mem_wdata = '0;

        tbl[0]  = '{1'b1, PB + 0,  32'd3,          {5'd0, 5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 5'd0, 5'd3}};
        tbl[1]  = '{1'b1, PB + 4,  32'd7,          {5'd0, 5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 5'd7, 5'd3}};
        tbl[2]  = '{1'b1, PB + 8,  32'd9,          {5'd0, 5'd0, 5'd0, 5'd0,  5'd0,  5'd9, 5'd7, 5'd3}};
        tbl[3]  = '{1'b1, PB + 12, 32'd12,         {5'd0, 5'd0, 5'd0, 5'd0,  5'd12, 5'd9, 5'd7, 5'd3}};
        tbl[4]  = '{1'b1, PB + 16, 32'd17,         {5'd0, 5'd0, 5'd0, 5'd17, 5'd12, 5'd9, 5'd7, 5'd3}};
        tbl[5]  = '{1'b1, PB + 2,  32'd31,         {5'd0, 5'd0, 5'd0, 5'd17, 5'd12, 5'd9, 5'd7, 5'd3}};
        tbl[6]  = '{1'b1, PB + 32, 32'd31,         {5'd0, 5'd0, 5'd0, 5'd17, 5'd12, 5'd9, 5'd7, 5'd3}};
        tbl[7]  = '{1'b0, PB + 20, 32'd25,         {5'd0, 5'd0, 5'd0, 5'd17, 5'd12, 5'd9, 5'd7, 5'd3}};
        tbl[8]  = '{1'b1, PB + 28, 32'd21,         {5'd21, 5'd0, 5'd0, 5'd17, 5'd12, 5'd9, 5'd7, 5'd3}};
        tbl[9]  = '{1'b1, PB + 28, 32'd5,          {5'd5, 5'd0, 5'd0, 5'd17, 5'd12, 5'd9, 5'd7, 5'd3}};
        tbl[10] = '{1'b1, PB + 24, 32'hFFFF_FFE6,  {5'd5, 5'd6, 5'd0, 5'd17, 5'd12, 5'd9, 5'd7, 5'd3}};

        #2;
        chk_reset_vals("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Start with sp=3, ep=17: two argument writes, then CPU release.
        @(negedge clk);
        start = 1'b1;
        sp = 5'd3;
        ep = 5'd17;
        @(posedge clk);
        #1;
        chk("load_sp ext", {bus_if.ext_active, bus_if.ext_memwrite, bus_if.ext_dataadr}, {2'b11, AB});
        chk("load_sp data", 64'(bus_if.ext_writedata), 64'd3);
        chk("load_sp hold", {cpu_reset, busy}, 2'b11);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("load_ep ext", {bus_if.ext_active, bus_if.ext_memwrite, bus_if.ext_dataadr}, {2'b11, AB + 32'd4});
        chk("load_ep data", 64'(bus_if.ext_writedata), 64'd17);
        chk("load_ep hold", 64'(cpu_reset), 64'd1);
        @(posedge clk);
        #1;
        chk("run release", {cpu_reset, busy}, 2'b01);
        chk("run ext idle", {bus_if.ext_active, bus_if.ext_memwrite, bus_if.ext_dataadr, bus_if.ext_writedata}, 66'd0);

        for (int i = 0; i < 11; i++) begin
            wr(tbl[i].we, tbl[i].adr, tbl[i].wd);
            chk($sformatf("vec%0d nodes", i), 64'(path_nodes), 64'(tbl[i].exp));
        end

        wr(1'b1, LA, 32'd5);
        chk("len5 flags", {path_len, done, path_found, timeout, busy, cpu_reset}, {4'd5, 5'b11001});
        chk("len5 low slots", 64'(path_nodes[24:0]), 64'({5'd17, 5'd12, 5'd9, 5'd7, 5'd3}));

        wr(1'b1, PB, 32'd30);
        chk("done write ignored", 64'(path_nodes), 64'(tbl[10].exp));
        do_ack();
        chk("ack hold flags", {path_len, done, path_found, busy}, {4'd5, 3'b110});
        chk("ack hold nodes", 64'(path_nodes), 64'(tbl[10].exp));

        go_run(5'd1, 5'd2);
        chk("start clears slots", 64'(path_nodes), 64'd0);
        wr(1'b1, LA, 32'd0);
        chk("len0 flags", {path_len, done, path_found, timeout}, {4'd0, 3'b100});
        do_ack();

        go_run(5'd4, 5'd9);
        wr(1'b1, LA, 32'd40);
        chk("len40 clamp", {path_len, done, path_found}, {4'd8, 2'b11});
        do_ack();

        // Timeout at RUN cycle 16, with a stray start ignored midway.
        go_run(5'd2, 5'd6);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start = (k == 5);
            @(posedge clk);
            #1;
            if (k == 15) chk("pre-timeout", {timeout, done, busy}, 3'b001);
        end
        start = 1'b0;
        chk("timeout flags", {timeout, done, path_found, busy, cpu_reset}, 5'b11001);
        do_ack();
        chk("timeout ack idle", {timeout, done, busy, cpu_reset}, 4'b1101);

        // LEN_ADDR write on the final RUN cycle wins over the timeout.
        go_run(5'd2, 5'd6);
        repeat (15) @(posedge clk);
        wr(1'b1, LA, 32'd2);
        chk("len beats timeout", {path_len, done, path_found, timeout}, {4'd2, 3'b110});
        do_ack();

        // Asynchronous reset in the middle of a run.
        go_run(5'd3, 5'd17);
        wr(1'b1, PB + 0, 32'd3);
        wr(1'b1, PB + 4, 32'd7);
        wr(1'b1, PB + 8, 32'd9);
        chk("pre-reset nodes", 64'(path_nodes), 64'(tbl[2].exp));
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrun reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset idle", {cpu_reset, busy, done}, 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
